// File: rtl/spi_pkg.sv
// spi_pkg: shared command-field positions, byte width and state encoding for the SPI slave
package spi_pkg;
   localparam int BYTE_W        = 8;
   localparam int CMD_RW_BIT    = 7;
   localparam int CMD_BURST_BIT = 6;
   typedef enum logic [1:0] {IDLE, CMD, DATA, IGNORE} spi_state_e;
endpackage

// File: rtl/spi_edge_sync.sv
// spi_edge_sync: multi-flop synchroniser with one-cycle rise/fall strobes on the synchronised level
module spi_edge_sync #(
   parameter int   STAGES  = 2,
   parameter logic RST_VAL = 1'b0
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q,
   output logic rise,
   output logic fall
);
   logic [STAGES-1:0] sync_q, sync_d;
   logic              prev_q, prev_d;
   always_comb begin
      sync_d = {sync_q[STAGES-2:0], d};
      prev_d = sync_q[STAGES-1];
   end
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         sync_q <= {STAGES{RST_VAL}};
         prev_q <= RST_VAL;
      end else begin
         sync_q <= sync_d;
         prev_q <= prev_d;
      end
   assign q    = sync_q[STAGES-1];
   assign rise = q & ~prev_q;
   assign fall = ~q & prev_q;
endmodule

// File: rtl/spi_slave_responder.sv
// spi_slave_responder: SPI mode-0 register-file slave in the clk domain; SPI_SLAVE_BURST_EN enables burst addressing
module spi_slave_responder
   import spi_pkg::*;
#(
   parameter int ADDR_W      = 6,
   parameter int SYNC_STAGES = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              ss,
   input  logic              sck,
   input  logic              mosi,
   output logic              miso,
   input  logic [BYTE_W-1:0] status_in,
   output logic              wr_strobe,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [BYTE_W-1:0] wr_data,
   input  logic [ADDR_W-1:0] lcl_addr,
   output logic [BYTE_W-1:0] lcl_rdata,
   output logic              busy
);
   logic ss_s, ss_fall, ss_rise_unused;
   logic sck_rise, sck_fall, sck_lvl_unused;
   logic mosi_s, mosi_rise_unused, mosi_fall_unused;

   spi_edge_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_ss (
      .clk(clk), .rst(rst), .d(ss), .q(ss_s), .rise(ss_rise_unused), .fall(ss_fall)
   );
   spi_edge_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sck (
      .clk(clk), .rst(rst), .d(sck), .q(sck_lvl_unused), .rise(sck_rise), .fall(sck_fall)
   );
   spi_edge_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_mosi (
      .clk(clk), .rst(rst), .d(mosi), .q(mosi_s), .rise(mosi_rise_unused), .fall(mosi_fall_unused)
   );

   spi_state_e        state_q, state_d;
   logic [2:0]        bit_cnt_q, bit_cnt_d;
   logic [BYTE_W-2:0] rx_q, rx_d;
   logic [BYTE_W-2:0] tx_q, tx_d;
   logic              miso_q, miso_d;
   logic              rw_q, rw_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [BYTE_W-1:0] regs_q [2**ADDR_W];
   logic [BYTE_W-1:0] regs_d [2**ADDR_W];
   logic              wr_strobe_q, wr_strobe_d;
   logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
   logic [BYTE_W-1:0] wr_data_q, wr_data_d;
   logic [BYTE_W-1:0] lcl_rdata_q, lcl_rdata_d;
   logic [BYTE_W-1:0] byte_in;
   logic [ADDR_W-1:0] rd_addr;
`ifdef SPI_SLAVE_BURST_EN
   logic              burst_q, burst_d;
`endif

   // tx_q holds only the bits still to be shifted; the current bit already sits on miso_q
   always_comb begin
      state_d     = state_q;
      bit_cnt_d   = bit_cnt_q;
      rx_d        = rx_q;
      tx_d        = tx_q;
      miso_d      = miso_q;
      rw_d        = rw_q;
      addr_d      = addr_q;
      regs_d      = regs_q;
      wr_strobe_d = 1'b0;
      wr_addr_d   = wr_addr_q;
      wr_data_d   = wr_data_q;
      byte_in     = {rx_q, mosi_s};
      rd_addr     = byte_in[ADDR_W-1:0];
`ifdef SPI_SLAVE_BURST_EN
      burst_d     = burst_q;
      if (state_q == DATA) rd_addr = addr_q + ADDR_W'(1);
`endif
      if (ss_s) begin
         state_d   = IDLE;
         bit_cnt_d = '0;
         miso_d    = 1'b0;
      end else if (state_q == IDLE) begin
         if (ss_fall) begin
            state_d          = CMD;
            {miso_d, tx_d}   = status_in;
         end
      end else if (state_q == IGNORE) begin
         miso_d = 1'b0;
      end else begin
         if (sck_rise) begin
            rx_d      = byte_in[BYTE_W-2:0];
            bit_cnt_d = bit_cnt_q + 3'd1;
         end
         if (sck_fall && bit_cnt_q != 3'd0) {miso_d, tx_d} = {tx_q, 1'b0};
         if (sck_rise && bit_cnt_q == 3'd7) begin
            if (state_q == CMD) begin
               rw_d    = byte_in[CMD_RW_BIT];
               addr_d  = byte_in[ADDR_W-1:0];
`ifdef SPI_SLAVE_BURST_EN
               burst_d = byte_in[CMD_BURST_BIT];
`endif
               state_d = DATA;
            end else begin
               if (!rw_q) begin
                  regs_d[addr_q] = byte_in;
                  wr_strobe_d    = 1'b1;
                  wr_addr_d      = addr_q;
                  wr_data_d      = byte_in;
               end
`ifdef SPI_SLAVE_BURST_EN
               if (burst_q) addr_d = rd_addr;
               else state_d = IGNORE;
`else
               state_d = IGNORE;
`endif
            end
            // next byte's MSB is presented straight after the boundary rise; the following fall must not shift
            {miso_d, tx_d} = (rw_d && state_d == DATA) ? regs_q[rd_addr] : '0;
         end
      end
      lcl_rdata_d = regs_d[lcl_addr];
   end

   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         state_q     <= IDLE;
         bit_cnt_q   <= '0;
         rx_q        <= '0;
         tx_q        <= '0;
         miso_q      <= 1'b0;
         rw_q        <= 1'b0;
         addr_q      <= '0;
         regs_q      <= '{default: '0};
         wr_strobe_q <= 1'b0;
         wr_addr_q   <= '0;
         wr_data_q   <= '0;
         lcl_rdata_q <= '0;
`ifdef SPI_SLAVE_BURST_EN
         burst_q     <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         bit_cnt_q   <= bit_cnt_d;
         rx_q        <= rx_d;
         tx_q        <= tx_d;
         miso_q      <= miso_d;
         rw_q        <= rw_d;
         addr_q      <= addr_d;
         regs_q      <= regs_d;
         wr_strobe_q <= wr_strobe_d;
         wr_addr_q   <= wr_addr_d;
         wr_data_q   <= wr_data_d;
         lcl_rdata_q <= lcl_rdata_d;
`ifdef SPI_SLAVE_BURST_EN
         burst_q     <= burst_d;
`endif
      end

   assign miso      = miso_q;
   assign wr_strobe = wr_strobe_q;
   assign wr_addr   = wr_addr_q;
   assign wr_data   = wr_data_q;
   assign lcl_rdata = lcl_rdata_q;
   assign busy      = ~ss_s;
endmodule
